hd44780_nybble_reader: RTL and testbench
========================================

# hd44780_nybble_reader

Read-side counterpart of the HD44780 nybble sender. Drives R/W high, strobes E twice in 4-bit mode, and assembles the returned high and low nybbles into a byte: either the busy flag plus address counter (rs_sel=0) or DDRAM/CGRAM data (rs_sel=1). An optional busy-poll mode repeats status reads until BF clears or a limit is reached, so the controller can replace fixed delays with real busy waits. It sits beside the nybble sender under the controller, with the top muxing the LCD pins.

## Interface
- TAS_TICKS, default `H4NS_TICKS_TAS (3): RS/RW setup before E rise, in clocks.
- PWEH_TICKS, default `H4NS_TICKS_PWEH (22): E high width, in clocks.
- TCYCE_TICKS, default `H4NS_TICKS_TCYCE (48): full E cycle, in clocks. Must be greater than PWEH_TICKS.
- COUNT_BITS, default `H4NS_COUNT_BITS (6): tick counter width.
- POLL_LIMIT, default 255: maximum status reads per poll request (at least 1).
- CLK_I  in  1  system clock; single clock domain.
- RST_I  in  1  synchronous, active-high reset.
- start_strobe  in  1  one-cycle request; ignored unless idle.
- rs_sel  in  1  RS value for the read; captured at start.
- poll_busy  in  1  1 = repeat status reads until BF=0; captured at start; forced off when rs_sel=1.
- end_strobe  out  1  one-cycle completion pulse.
- DAT_O  out  8  last assembled byte; held until the next completion.
- timeout  out  1  valid with end_strobe; 1 = poll limit hit with BF still set.
- lcd_rs  out  1  RS pin.
- lcd_rw  out  1  R/W pin; 1 only during a read.
- lcd_e  out  1  E pin.
- lcd_data_i  in  4  DB7..DB4 from the pad input.
- lcd_data_oe  out  1  0 = reader has released the data bus (FPGA must not drive).

## Operation
- Reset and idle values: lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_data_oe=1, end_strobe=0, timeout=0, DAT_O=8'h00. Internal state: IDLE, nybble index 0, read count 0.
- States are IDLE, SETUP, E_HI, E_LO, DONE.
- IDLE:
  - When start_strobe is high, capture rs_sel and poll_busy (gated by ~rs_sel).
  - Next cycle: lcd_rw=1, lcd_data_oe=0, lcd_rs=captured value. Enter SETUP.
- SETUP: hold for TAS_TICKS cycles with E low, then enter E_HI.
- E_HI:
  - Hold lcd_e=1 for PWEH_TICKS cycles.
  - On the last E-high cycle, sample lcd_data_i into DAT_O[7:4] (index 0) or DAT_O[3:0] (index 1).
  - Enter E_LO.
- E_LO:
  - Hold lcd_e=0 for TCYCE_TICKS−PWEH_TICKS cycles.
  - If index 0: toggle the index, go to E_HI.
  - If index 1 and polling, DAT_O[7]=1, and read count < POLL_LIMIT: increment the count, clear the index, go to E_HI. No new SETUP is needed because RS/RW are unchanged.
  - Otherwise go to DONE.
- DONE (one cycle):
  - end_strobe=1; lcd_rw=0.
  - timeout = polling & DAT_O[7].
  - lcd_data_oe stays 0 this cycle and returns to 1 on the next cycle, in IDLE.
- DAT_O is partially updated while a read is in progress. It is only meaningful at end_strobe.
- start_strobe in any state other than IDLE is dropped; it is not queued.
- RST_I mid-operation: on the next edge every output takes its reset value, E drops immediately, and no end_strobe is issued.
- lcd_rs, lcd_rw and lcd_e are registered outputs.

## Timing
- start_strobe at cycle N gives lcd_rw=1 at N+1 and the first E rise at N+1+TAS_TICKS.
- With defaults, a single read gives E high during cycles N+4..N+25 and N+52..N+73, and end_strobe at N+100 (that is, N+1+TAS+2·TCYCE).
- Each extra poll read adds 2·TCYCE_TICKS (96 cycles).
- A full timeout with defaults gives end_strobe at N+4+96·255.
- Sampling on the last E-high cycle meets tDDR (max 160 ns) for every PWEH_TICKS ≥ 2 at 6 MHz and ≥ 8 at 48 MHz.
- Back-to-back: start_strobe is accepted at the earliest one cycle after end_strobe.

## Structure
- The H4NS_* tick defines come from the shared build/sim config includes. Add H4NS_BUSY_POLL_LIMIT there.
- The state encoding is a local parameter, not shared.
- One COUNT_BITS down-counter is reloaded on every state entry. No sub-module; the long-delay hd44780_state_timer is not used.

## Test plan
- Status read: rs_sel=0, poll_busy=0; lcd_data_i=4'h3 during E pulse 1 and 4'hA during pulse 2 → DAT_O=8'h3A, timeout=0, end_strobe at N+100.
- Data read: rs_sel=1 → lcd_rs=1 throughout. poll_busy=1 is ignored: exactly 2 E pulses even with DB7=1.
- Poll: BF=1 for the first 3 reads, then 8'h05 → 8 E pulses, end_strobe at N+4+4·96, DAT_O=8'h05, timeout=0.
- Timeout (sim POLL_LIMIT=4): BF stuck at 1 → 8 E pulses, then end_strobe with timeout=1 and DAT_O[7]=1.
- Pin discipline: lcd_data_oe=0 whenever lcd_rw=1 and for one cycle after; lcd_rw never changes while lcd_e=1; start_strobe pulses mid-read are ignored.
- Reset mid-read: RST_I during the second E_HI → next cycle lcd_e=0, lcd_rw=0, lcd_data_oe=1, DAT_O=0, no end_strobe; a following read completes normally.

Source files
------------

// File: rtl/hd44780_nybble_reader_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | hd44780_nybble_reader_pkg : tick defaults and nybble helpers        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+

`ifndef H4NS_TICKS_TAS
`define H4NS_TICKS_TAS 3
`endif
`ifndef H4NS_TICKS_PWEH
`define H4NS_TICKS_PWEH 22
`endif
`ifndef H4NS_TICKS_TCYCE
`define H4NS_TICKS_TCYCE 48
`endif
`ifndef H4NS_COUNT_BITS
`define H4NS_COUNT_BITS 6
`endif
`ifndef H4NS_BUSY_POLL_LIMIT
`define H4NS_BUSY_POLL_LIMIT 255
`endif

package hd44780_nybble_reader_pkg;

  typedef enum logic {
    NYB_HI = 1'b0,
    NYB_LO = 1'b1
  } nyb_idx_t;

  function automatic logic [7:0] merge_nybble(input logic [7:0] cur,
                                              input nyb_idx_t   idx,
                                              input logic [3:0] nyb);
    logic [7:0] res;
    res = cur;
    if (idx == NYB_HI) res[7:4] = nyb;
    else               res[3:0] = nyb;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hd44780_nybble_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | hd44780_nybble_reader : 4-bit HD44780 read with optional busy poll  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+

module hd44780_nybble_reader
  import hd44780_nybble_reader_pkg::*;
#(
  parameter int TAS_TICKS   = `H4NS_TICKS_TAS,
  parameter int PWEH_TICKS  = `H4NS_TICKS_PWEH,
  parameter int TCYCE_TICKS = `H4NS_TICKS_TCYCE,
  parameter int COUNT_BITS  = `H4NS_COUNT_BITS,
  parameter int POLL_LIMIT  = `H4NS_BUSY_POLL_LIMIT
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       start_strobe,
  input  logic       rs_sel,
  input  logic       poll_busy,
  output logic       end_strobe,
  output logic [7:0] DAT_O,
  output logic       timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  input  logic [3:0] lcd_data_i,
  output logic       lcd_data_oe
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_E_HI  = 3'd2,
    S_E_LO  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Repeat counter only has to reach POLL_LIMIT-1 (reads beyond the first).
  localparam int c_CNT_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam logic [c_CNT_W-1:0]    c_LIMIT_M1 = c_CNT_W'(POLL_LIMIT - 1);
  localparam logic [COUNT_BITS-1:0] c_TAS_LD   = COUNT_BITS'(TAS_TICKS - 1);
  localparam logic [COUNT_BITS-1:0] c_PWEH_LD  = COUNT_BITS'(PWEH_TICKS - 1);
  localparam logic [COUNT_BITS-1:0] c_ELO_LD   = COUNT_BITS'(TCYCE_TICKS - PWEH_TICKS - 1);

  state_t                r_state, w_state_nxt;
  logic [COUNT_BITS-1:0] r_timer, w_timer_nxt;
  nyb_idx_t              r_idx, w_idx_nxt;
  logic [c_CNT_W-1:0]    r_count, w_count_nxt;
  logic [7:0]            r_dat, w_dat_nxt;
  logic                  r_rs, r_poll;
  logic                  r_end, r_timeout, w_timeout_nxt;
  logic                  r_lcd_rs, r_lcd_rw, r_lcd_e, r_lcd_oe;
  logic                  w_timer_done, w_active, w_owned, w_rs_cap;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_count_nxt   = r_count;
    w_dat_nxt     = r_dat;
    w_timeout_nxt = 1'b0;
    w_timer_nxt   = r_timer;
    w_timer_done  = (r_timer == '0);

    case (r_state)
      S_IDLE: begin
        if (start_strobe) begin
          w_state_nxt = S_SETUP;
          w_idx_nxt   = NYB_HI;
          w_count_nxt = '0;
        end
      end
      S_SETUP: if (w_timer_done) w_state_nxt = S_E_HI;
      S_E_HI: begin
        if (w_timer_done) begin
          w_dat_nxt   = merge_nybble(r_dat, r_idx, lcd_data_i);
          w_state_nxt = S_E_LO;
        end
      end
      S_E_LO: begin
        if (w_timer_done) begin
          if (r_idx == NYB_HI) begin
            w_idx_nxt   = NYB_LO;
            w_state_nxt = S_E_HI;
          end else if (r_poll && r_dat[7] && (r_count < c_LIMIT_M1)) begin
            // RS/RW are already settled, so a repeat read skips SETUP.
            w_count_nxt = r_count + 1'b1;
            w_idx_nxt   = NYB_HI;
            w_state_nxt = S_E_HI;
          end else begin
            w_timeout_nxt = r_poll & r_dat[7];
            w_state_nxt   = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        S_SETUP: w_timer_nxt = c_TAS_LD;
        S_E_HI:  w_timer_nxt = c_PWEH_LD;
        S_E_LO:  w_timer_nxt = c_ELO_LD;
        default: w_timer_nxt = '0;
      endcase
    end else if (!w_timer_done) begin
      w_timer_nxt = r_timer - 1'b1;
    end
  end

  // Pins are registered from the next state so they line up with it.
  assign w_active = (w_state_nxt == S_SETUP) || (w_state_nxt == S_E_HI) ||
                    (w_state_nxt == S_E_LO);
  assign w_owned  = w_active || (w_state_nxt == S_DONE);
  assign w_rs_cap = (r_state == S_IDLE) ? rs_sel : r_rs;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_idx     <= NYB_HI;
      r_count   <= '0;
      r_rs      <= 1'b0;
      r_poll    <= 1'b0;
      r_dat     <= 8'h00;
      r_end     <= 1'b0;
      r_timeout <= 1'b0;
      r_lcd_rs  <= 1'b0;
      r_lcd_rw  <= 1'b0;
      r_lcd_e   <= 1'b0;
      r_lcd_oe  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_idx     <= w_idx_nxt;
      r_count   <= w_count_nxt;
      r_dat     <= w_dat_nxt;
      r_end     <= (w_state_nxt == S_DONE);
      r_timeout <= w_timeout_nxt;
      r_lcd_rs  <= w_owned ? w_rs_cap : 1'b0;
      r_lcd_rw  <= w_active;
      r_lcd_e   <= (w_state_nxt == S_E_HI);
      r_lcd_oe  <= ~w_owned;
      if ((r_state == S_IDLE) && start_strobe) begin
        r_rs   <= rs_sel;
        r_poll <= poll_busy & ~rs_sel;
      end
    end
  end

  assign end_strobe  = r_end;
  assign DAT_O       = r_dat;
  assign timeout     = r_timeout;
  assign lcd_rs      = r_lcd_rs;
  assign lcd_rw      = r_lcd_rw;
  assign lcd_e       = r_lcd_e;
  assign lcd_data_oe = r_lcd_oe;

endmodule

`default_nettype wire

// File: tb/tb_hd44780_nybble_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_hd44780_nybble_reader : LCD model, cycle pin model, directed reads |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+

module tb_hd44780_nybble_reader;

  localparam int TAS   = 3;
  localparam int PWEH  = 22;
  localparam int TCYCE = 48;
  localparam int CBITS = 6;
  localparam int PLIM  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_strobe = 1'b0;
  logic       rs_sel = 1'b0;
  logic       poll_busy = 1'b0;
  logic       end_strobe;
  logic [7:0] dat;
  logic       timeout;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_data_oe;
  logic [3:0] lcd_data_i = 4'h0;

  hd44780_nybble_reader #(
    .TAS_TICKS  (TAS),
    .PWEH_TICKS (PWEH),
    .TCYCE_TICKS(TCYCE),
    .COUNT_BITS (CBITS),
    .POLL_LIMIT (PLIM)
  ) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .start_strobe(start_strobe),
    .rs_sel      (rs_sel),
    .poll_busy   (poll_busy),
    .end_strobe  (end_strobe),
    .DAT_O       (dat),
    .timeout     (timeout),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_e       (lcd_e),
    .lcd_data_i  (lcd_data_i),
    .lcd_data_oe (lcd_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LCD side: byte k answers read k, the last byte repeats for later reads.
  logic [7:0] lcd_bytes [4];
  int         lcd_n = 1;
  int         lcd_gen = 0;
  int         seen_gen = 0;
  int         pk = 0;
  logic [7:0] lcd_b;
  logic [3:0] lcd_nyb;

  function automatic logic [7:0] byte_of(input int k);
    int i;
    i = (k > lcd_n - 1) ? lcd_n - 1 : k;
    return lcd_bytes[i[1:0]];
  endfunction

  // Garbage right after E rises, valid data later in the pulse.
  always @(posedge lcd_e) begin
    if (lcd_gen != seen_gen) begin
      pk       = 0;
      seen_gen = lcd_gen;
    end
    lcd_b      = byte_of(pk / 2);
    lcd_nyb    = (pk % 2 == 1) ? lcd_b[3:0] : lcd_b[7:4];
    pk         = pk + 1;
    lcd_data_i = ~lcd_nyb;
    #20 lcd_data_i = lcd_nyb;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Current transaction as predicted from the bus rules.
  bit         live = 1'b0;
  int         t_N = 0;
  int         t_R = 1;
  logic       t_rs = 1'b0;
  logic       t_pe = 1'b0;
  logic [7:0] t_byte = 8'h00;
  logic       t_to = 1'b0;
  logic [7:0] last_byte = 8'h00;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int model_reads(input logic pe);
    int r;
    if (!pe) return 1;
    r = 1;
    while (r < PLIM && byte_of(r - 1) >= 8'h80) r++;
    return r;
  endfunction

  task automatic check_cycle();
    int rel, endc;
    bit rw_exp, e_exp;
    rel  = cyc - t_N;
    endc = 1 + TAS + 2 * TCYCE * t_R;
    if (live && rel >= 1 && rel <= endc) begin
      rw_exp = (rel < endc);
      e_exp  = rw_exp && (rel >= 1 + TAS) && (((rel - 1 - TAS) % TCYCE) < PWEH);
      chk1("rw", lcd_rw, rw_exp);
      chk1("e", lcd_e, e_exp);
      chk1("oe_busy", lcd_data_oe, 1'b0);
      chk1("end", end_strobe, rel == endc);
      if (rw_exp) chk1("rs", lcd_rs, t_rs);
      if (rel == endc) begin
        chk8("dat_end", dat, t_byte);
        chk1("timeout_end", timeout, t_to);
        last_byte = t_byte;
      end
    end else begin
      chk1("idle_rs", lcd_rs, 1'b0);
      chk1("idle_rw", lcd_rw, 1'b0);
      chk1("idle_e", lcd_e, 1'b0);
      chk1("idle_oe", lcd_data_oe, 1'b1);
      chk1("idle_end", end_strobe, 1'b0);
      chk1("idle_timeout", timeout, 1'b0);
      chk8("idle_dat", dat, last_byte);
    end
  endtask

  task automatic run_compare();
    bit rst_prev = 1'b0;
    bit armed = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        armed     = 1'b1;
        live      = 1'b0;
        last_byte = 8'h00;
        chk1("rst_rs", lcd_rs, 1'b0);
        chk1("rst_rw", lcd_rw, 1'b0);
        chk1("rst_e", lcd_e, 1'b0);
        chk1("rst_oe", lcd_data_oe, 1'b1);
        chk1("rst_end", end_strobe, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk8("rst_dat", dat, 8'h00);
      end else if (armed) begin
        check_cycle();
      end
      rst_prev = rst;
    end
  endtask

  task automatic set_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    lcd_n        = n;
    lcd_bytes[0] = b0;
    lcd_bytes[1] = b1;
    lcd_bytes[2] = b2;
    lcd_bytes[3] = b3;
  endtask

  task automatic start_txn(input logic rs, input logic poll);
    @(posedge clk); #1;
    lcd_gen++;
    t_rs   = rs;
    t_pe   = poll & ~rs;
    t_R    = model_reads(t_pe);
    t_byte = byte_of(t_R - 1);
    t_to   = t_pe & t_byte[7];
    t_N    = cyc;
    live   = 1'b1;
    rs_sel = rs;
    poll_busy    = poll;
    start_strobe = 1'b1;
    @(posedge clk); #1;
    start_strobe = 1'b0;
    rs_sel    = ~rs;
    poll_busy = ~poll;
  endtask

  task automatic do_read(input string nm, input logic rs, input logic poll, input bit stray,
                         input int lit_end, input logic [7:0] lit_dat, input logic lit_to,
                         input int lit_pulses);
    int rel;
    int waited;
    start_txn(rs, poll);
    waited = 0;
    while (!end_strobe && waited < 1000) begin
      rel = cyc - t_N;
      start_strobe = stray && (rel == 30 || rel == 150 || rel == 300);
      @(posedge clk); #1;
      waited++;
    end
    start_strobe = 1'b0;
    if (!end_strobe) begin
      chk1({nm, "_end_seen"}, end_strobe, 1'b1);
    end else begin
      chkn({nm, "_latency"}, cyc - t_N, lit_end);
      chk8({nm, "_dat"}, dat, lit_dat);
      chk1({nm, "_timeout"}, timeout, lit_to);
      chkn({nm, "_pulses"}, pk, lit_pulses);
    end
  endtask

  initial begin
    fork
      run_compare();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    set_bytes(1, 8'h3A, 8'h00, 8'h00, 8'h00);
    do_read("status", 1'b0, 1'b0, 1'b0, 100, 8'h3A, 1'b0, 2);
    set_bytes(1, 8'hC5, 8'h00, 8'h00, 8'h00);
    do_read("data_b2b", 1'b1, 1'b1, 1'b0, 100, 8'hC5, 1'b0, 2);
    repeat (4) @(posedge clk);

    set_bytes(4, 8'h8F, 8'h91, 8'hA2, 8'h05);
    do_read("poll", 1'b0, 1'b1, 1'b1, 388, 8'h05, 1'b0, 8);
    repeat (4) @(posedge clk);

    set_bytes(1, 8'hFF, 8'h00, 8'h00, 8'h00);
    do_read("poll_timeout", 1'b0, 1'b1, 1'b0, 388, 8'hFF, 1'b1, 8);
    repeat (4) @(posedge clk);

    set_bytes(1, 8'hE7, 8'h00, 8'h00, 8'h00);
    do_read("status_bf", 1'b0, 1'b0, 1'b0, 100, 8'hE7, 1'b0, 2);
    repeat (4) @(posedge clk);

    // Reset inside the second E-high window.
    set_bytes(1, 8'h3A, 8'h00, 8'h00, 8'h00);
    start_txn(1'b0, 1'b0);
    while (cyc - t_N < 60) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("abort_e", lcd_e, 1'b0);
    chk1("abort_rw", lcd_rw, 1'b0);
    chk1("abort_oe", lcd_data_oe, 1'b1);
    chk8("abort_dat", dat, 8'h00);
    repeat (120) @(posedge clk);

    set_bytes(1, 8'h5C, 8'h00, 8'h00, 8'h00);
    do_read("after_reset", 1'b0, 1'b0, 1'b0, 100, 8'h5C, 1'b0, 2);
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
